// File: rtl/synth_pkg.sv
// Shared types and default sizing for the voice allocator and its per-voice slots.
package synth_pkg;

  typedef enum logic [1:0] {
    FREE      = 2'd0,
    ARM       = 2'd1,
    HELD      = 2'd2,
    RELEASING = 2'd3
  } voice_state_t;

  localparam int NUM_VOICES_DEF = 4;
  localparam int KEY_W_DEF      = 7;
  localparam int ARM_CYCLES_DEF = 2;

endpackage

// File: rtl/voice_slot.sv
// One voice: FREE/ARM/HELD/RELEASING state machine, arm counter, start pulse and key.
module voice_slot
  import synth_pkg::*;
#(
  parameter int KEY_W      = KEY_W_DEF,
  parameter int ARM_CYCLES = ARM_CYCLES_DEF
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             i_alloc,
  input  logic             i_release,
  input  logic             i_panic,
  input  logic             i_idle,
  input  logic [KEY_W-1:0] i_key,
  output logic             o_start,
  output logic             o_hold,
  output logic [KEY_W-1:0] o_key,
  output voice_state_t     o_state
);

  localparam int CW = $clog2(ARM_CYCLES);

  voice_state_t     r_state, w_state_nx;
  logic [CW-1:0]    r_cnt, w_cnt_nx;
  logic             r_pend, w_pend_nx;
  logic             r_start, w_start_nx;
  logic [KEY_W-1:0] r_key, w_key_nx;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= FREE;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_start <= 1'b0;
      r_key   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_pend  <= w_pend_nx;
      r_start <= w_start_nx;
      r_key   <= w_key_nx;
    end
  end

  // Panic beats allocation; allocation (retrigger/steal) beats everything else.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_pend_nx  = r_pend;
    w_start_nx = 1'b0;
    w_key_nx   = r_key;
    if (i_panic) begin
      if (r_state == ARM || r_state == HELD) begin
        w_state_nx = RELEASING;
        w_pend_nx  = 1'b0;
      end else if (r_state == RELEASING && i_idle) begin
        w_state_nx = FREE;
      end
    end else if (i_alloc) begin
      w_state_nx = ARM;
      w_start_nx = 1'b1;
      w_key_nx   = i_key;
      w_cnt_nx   = CW'(ARM_CYCLES - 1);
      w_pend_nx  = 1'b0;
    end else begin
      case (r_state)
        ARM: begin
          // A release landing on the final arm cycle is honoured immediately.
          if (r_cnt == '0) begin
            w_state_nx = (r_pend || i_release) ? RELEASING : HELD;
            w_pend_nx  = 1'b0;
          end else begin
            w_cnt_nx = r_cnt - 1'b1;
            if (i_release) w_pend_nx = 1'b1;
          end
        end
        HELD:      if (i_release) w_state_nx = RELEASING;
        RELEASING: if (i_idle)    w_state_nx = FREE;
        default:   ;
      endcase
    end
  end

  assign o_start = r_start;
  assign o_hold  = (r_state == ARM) || (r_state == HELD);
  assign o_key   = r_key;
  assign o_state = r_state;

endmodule

// File: rtl/voice_allocator.sv
// Key event capture, voice selection (retrigger/free/releasing/steal) and per-voice slots.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int KEY_W      = KEY_W_DEF,
  parameter int ARM_CYCLES = ARM_CYCLES_DEF
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        key_valid,
  output logic                        key_ready,
  input  logic                        key_on,
  input  logic [KEY_W-1:0]            key_num,
  input  logic                        all_off,
  input  logic [NUM_VOICES-1:0]       adsr_idle,
  output logic [NUM_VOICES-1:0]       adsr_start,
  output logic [NUM_VOICES-1:0]       adsr_hold,
  output logic [NUM_VOICES*KEY_W-1:0] voice_key,
  output logic [NUM_VOICES-1:0]       voice_active
);

  localparam int PW = $clog2(NUM_VOICES);

  logic                             r_cap_vld;
  logic                             r_cap_on;
  logic [KEY_W-1:0]                 r_cap_key;
  logic [PW-1:0]                    r_steal_ptr;

  voice_state_t                     w_state [NUM_VOICES];
  logic [NUM_VOICES-1:0][KEY_W-1:0] w_key;
  logic [NUM_VOICES-1:0]            w_alloc, w_rel;
  logic                             w_steal;
  logic                             w_on_hit, w_free_hit, w_relg_hit, w_held_hit, w_arm_hit;
  logic [PW-1:0]                    w_on_idx, w_free_idx, w_relg_idx, w_held_idx, w_arm_idx;

  // Descending scans so the lowest matching index is the one left standing.
  always_comb begin
    w_on_hit   = 1'b0; w_on_idx   = '0;
    w_free_hit = 1'b0; w_free_idx = '0;
    w_relg_hit = 1'b0; w_relg_idx = '0;
    w_held_hit = 1'b0; w_held_idx = '0;
    w_arm_hit  = 1'b0; w_arm_idx  = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (w_state[v] != FREE && w_key[v] == r_cap_key) begin
        w_on_hit = 1'b1; w_on_idx = PW'(v);
      end
      if (w_state[v] == FREE) begin
        w_free_hit = 1'b1; w_free_idx = PW'(v);
      end
      if (w_state[v] == RELEASING) begin
        w_relg_hit = 1'b1; w_relg_idx = PW'(v);
      end
      if (w_state[v] == HELD && w_key[v] == r_cap_key) begin
        w_held_hit = 1'b1; w_held_idx = PW'(v);
      end
      if (w_state[v] == ARM && w_key[v] == r_cap_key) begin
        w_arm_hit = 1'b1; w_arm_idx = PW'(v);
      end
    end
  end

  always_comb begin
    w_alloc = '0;
    w_rel   = '0;
    w_steal = 1'b0;
    if (r_cap_vld && !all_off) begin
      if (r_cap_on) begin
        if (w_on_hit)        w_alloc[w_on_idx]   = 1'b1;
        else if (w_free_hit) w_alloc[w_free_idx] = 1'b1;
        else if (w_relg_hit) w_alloc[w_relg_idx] = 1'b1;
        else begin
          w_alloc[r_steal_ptr] = 1'b1;
          w_steal              = 1'b1;
        end
      end else begin
        if (w_held_hit)     w_rel[w_held_idx] = 1'b1;
        else if (w_arm_hit) w_rel[w_arm_idx]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cap_vld   <= 1'b0;
      r_cap_on    <= 1'b0;
      r_cap_key   <= '0;
      r_steal_ptr <= '0;
    end else begin
      // A panic edge swallows both the captured event and any event offered on it.
      if (all_off || r_cap_vld) begin
        r_cap_vld <= 1'b0;
      end else if (key_valid) begin
        r_cap_vld <= 1'b1;
        r_cap_on  <= key_on;
        r_cap_key <= key_num;
      end
      if (w_steal)
        r_steal_ptr <= (r_steal_ptr == PW'(NUM_VOICES - 1)) ? '0 : r_steal_ptr + 1'b1;
    end
  end

  assign key_ready = !r_cap_vld;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
    voice_slot #(
      .KEY_W      (KEY_W),
      .ARM_CYCLES (ARM_CYCLES)
    ) u_slot (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .i_alloc   (w_alloc[g]),
      .i_release (w_rel[g]),
      .i_panic   (all_off),
      .i_idle    (adsr_idle[g]),
      .i_key     (r_cap_key),
      .o_start   (adsr_start[g]),
      .o_hold    (adsr_hold[g]),
      .o_key     (w_key[g]),
      .o_state   (w_state[g])
    );
    assign voice_key[g*KEY_W +: KEY_W] = w_key[g];
    assign voice_active[g]             = (w_state[g] != FREE);
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: a per-cycle vector table plus hand-written corner sequences.
module tb_voice_allocator;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        key_valid, key_ready, key_on, all_off;
  logic [6:0]  key_num;
  logic [3:0]  adsr_idle, adsr_start, adsr_hold, voice_active;
  logic [27:0] voice_key;

  int n_checks = 0;
  int n_err    = 0;

  voice_allocator #(.NUM_VOICES(4), .KEY_W(7), .ARM_CYCLES(2)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .key_on       (key_on),
    .key_num      (key_num),
    .all_off      (all_off),
    .adsr_idle    (adsr_idle),
    .adsr_start   (adsr_start),
    .adsr_hold    (adsr_hold),
    .voice_key    (voice_key),
    .voice_active (voice_active)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        kv, ko;
    logic [6:0]  kn;
    logic        ao;
    logic [3:0]  idle;
    logic        rdy;
    logic [3:0]  st, hd, ac;
    logic [27:0] vk;
  } vec_t;

  vec_t tv[18];

  function automatic logic [27:0] pk(input int k0, k1, k2, k3);
    pk = {7'(k3), 7'(k2), 7'(k1), 7'(k0)};
  endfunction

  function automatic vec_t mk(input logic kv, ko, input int kn, input logic [3:0] idle,
                              input logic rdy, input logic [3:0] st, hd, ac,
                              input logic [27:0] vk);
    vec_t t;
    t.kv = kv; t.ko = ko; t.kn = 7'(kn); t.ao = 1'b0; t.idle = idle;
    t.rdy = rdy; t.st = st; t.hd = hd; t.ac = ac; t.vk = vk;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic kv, ko, input int kn, input logic ao, input logic [3:0] idle);
    key_valid = kv; key_on = ko; key_num = 7'(kn); all_off = ao; adsr_idle = idle;
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic rdy, input logic [3:0] st, hd, ac,
                         input logic [27:0] vk);
    chk({nm, " ready"},  32'(key_ready),    32'(rdy));
    chk({nm, " start"},  32'(adsr_start),   32'(st));
    chk({nm, " hold"},   32'(adsr_hold),    32'(hd));
    chk({nm, " active"}, 32'(voice_active), 32'(ac));
    chk({nm, " keys"},   32'(voice_key),    32'(vk));
  endtask

  task automatic do_reset();
    key_valid = 1'b0; key_on = 1'b0; key_num = '0; all_off = 1'b0; adsr_idle = '0;
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;
  endtask

  initial begin
    // Tests 1 and 2: fill all voices, then steal voice0 and voice1 in turn.
    tv[0]  = mk(1, 1, 60, 4'h0, 0, 4'h0, 4'h0, 4'h0, pk(0, 0, 0, 0));
    tv[1]  = mk(0, 0, 0,  4'h0, 1, 4'h1, 4'h1, 4'h1, pk(60, 0, 0, 0));
    tv[2]  = mk(0, 0, 0,  4'hF, 1, 4'h0, 4'h1, 4'h1, pk(60, 0, 0, 0));
    tv[3]  = mk(0, 0, 0,  4'hF, 1, 4'h0, 4'h1, 4'h1, pk(60, 0, 0, 0));
    tv[4]  = mk(1, 1, 62, 4'h0, 0, 4'h0, 4'h1, 4'h1, pk(60, 0, 0, 0));
    tv[5]  = mk(0, 0, 0,  4'h0, 1, 4'h2, 4'h3, 4'h3, pk(60, 62, 0, 0));
    tv[6]  = mk(1, 1, 64, 4'h0, 0, 4'h0, 4'h3, 4'h3, pk(60, 62, 0, 0));
    tv[7]  = mk(0, 0, 0,  4'h0, 1, 4'h4, 4'h7, 4'h7, pk(60, 62, 64, 0));
    tv[8]  = mk(1, 1, 65, 4'h0, 0, 4'h0, 4'h7, 4'h7, pk(60, 62, 64, 0));
    tv[9]  = mk(0, 0, 0,  4'h0, 1, 4'h8, 4'hF, 4'hF, pk(60, 62, 64, 65));
    tv[10] = mk(0, 0, 0,  4'h0, 1, 4'h0, 4'hF, 4'hF, pk(60, 62, 64, 65));
    tv[11] = mk(0, 0, 0,  4'h0, 1, 4'h0, 4'hF, 4'hF, pk(60, 62, 64, 65));
    tv[12] = mk(1, 1, 67, 4'h0, 0, 4'h0, 4'hF, 4'hF, pk(60, 62, 64, 65));
    tv[13] = mk(0, 0, 0,  4'h0, 1, 4'h1, 4'hF, 4'hF, pk(67, 62, 64, 65));
    tv[14] = mk(0, 0, 0,  4'h0, 1, 4'h0, 4'hF, 4'hF, pk(67, 62, 64, 65));
    tv[15] = mk(0, 0, 0,  4'h0, 1, 4'h0, 4'hF, 4'hF, pk(67, 62, 64, 65));
    tv[16] = mk(1, 1, 69, 4'h0, 0, 4'h0, 4'hF, 4'hF, pk(67, 62, 64, 65));
    tv[17] = mk(0, 0, 0,  4'h0, 1, 4'h2, 4'hF, 4'hF, pk(67, 69, 64, 65));

    do_reset();
    chk_all("reset", 1'b1, 4'h0, 4'h0, 4'h0, 28'h0);

    for (int i = 0; i < 18; i++) begin
      step(tv[i].kv, tv[i].ko, int'(tv[i].kn), tv[i].ao, tv[i].idle);
      chk_all($sformatf("vec%0d", i), tv[i].rdy, tv[i].st, tv[i].hd, tv[i].ac, tv[i].vk);
    end

    // Test 3: release while still arming, with adsr_idle high the whole time.
    do_reset();
    step(1, 1, 60, 0, 4'hF);
    step(0, 0, 0,  0, 4'hF);
    chk_all("t3 alloc", 1'b1, 4'h1, 4'h1, 4'h1, pk(60, 0, 0, 0));
    step(1, 0, 60, 0, 4'hF);
    chk("t3 arm ignores idle", 32'(voice_active), 32'h1);
    chk("t3 arm hold", 32'(adsr_hold), 32'h1);
    step(0, 0, 0, 0, 4'hF);
    chk("t3 releasing hold", 32'(adsr_hold), 32'h0);
    chk("t3 releasing active", 32'(voice_active), 32'h1);
    step(0, 0, 0, 0, 4'hF);
    chk("t3 freed", 32'(voice_active), 32'h0);
    chk("t3 key kept", 32'(voice_key), 32'(pk(60, 0, 0, 0)));

    // Tests 4 and 5: retrigger the same key, then an unmatched release.
    do_reset();
    step(1, 1, 60, 0, 4'h0);
    step(0, 0, 0,  0, 4'h0);
    chk("t4 first start", 32'(adsr_start), 32'h1);
    step(1, 1, 60, 0, 4'h0);
    chk("t4 pulse ends", 32'(adsr_start), 32'h0);
    step(0, 0, 0, 0, 4'h0);
    chk_all("t4 retrig", 1'b1, 4'h1, 4'h1, 4'h1, pk(60, 0, 0, 0));
    step(1, 0, 70, 0, 4'h0);
    chk("t5 ready low", 32'(key_ready), 32'h0);
    step(0, 0, 0, 0, 4'h0);
    chk_all("t5 no match", 1'b1, 4'h0, 4'h1, 4'h1, pk(60, 0, 0, 0));

    // Test 6: panic with a simultaneous press, then async reset mid-ARM.
    do_reset();
    step(1, 1, 50, 0, 4'h0); step(0, 0, 0, 0, 4'h0);
    step(1, 1, 52, 0, 4'h0); step(0, 0, 0, 0, 4'h0);
    step(1, 1, 54, 0, 4'h0); step(0, 0, 0, 0, 4'h0);
    step(0, 0, 0, 0, 4'h0); step(0, 0, 0, 0, 4'h0);
    chk("t6 held", 32'(adsr_hold), 32'h7);
    step(1, 1, 50, 1, 4'h0);
    chk_all("t6 panic", 1'b1, 4'h0, 4'h0, 4'h7, pk(50, 52, 54, 0));
    step(0, 0, 0, 0, 4'h0);
    chk_all("t6 dropped", 1'b1, 4'h0, 4'h0, 4'h7, pk(50, 52, 54, 0));
    step(0, 0, 0, 0, 4'hF);
    chk("t6 idle frees", 32'(voice_active), 32'h0);
    step(1, 1, 40, 0, 4'h0);
    step(0, 0, 0, 0, 4'h0);
    chk("t6 new start", 32'(adsr_start), 32'h1);
    #2 rst_in = 1'b1;
    #1;
    chk_all("t6 async rst", 1'b1, 4'h0, 4'h0, 4'h0, 28'h0);
    @(negedge clk_in);
    rst_in = 1'b0;
    step(0, 0, 0, 0, 4'h0);
    chk("t6 stays idle", 32'(voice_active), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
